seq_gen: RTL and testbench
==========================

// Module: seq_gen
// PURPOSE
//  Serial test-sequence generator: the transmit side of the single-bit serial
//  stream consumed by the sequence detectors.
//  - Latches a pattern of up to WIDTH bits and shifts it out MSB-first, one bit
//    per clock, with a valid qualifier.
//  - Repeats the pattern a programmed number of times (or continuously), with
//    an optional idle gap between repetitions.
//  - Drives detector inputs in unit benches and in on-chip self-test.
// PARAMETERS
//  WIDTH  8  maximum pattern length in bits
//  LEN_W  4  width of len; must hold the value WIDTH
//  REP_W  4  width of the repeat count
//  GAP    2  idle cycles between repetitions (0 = back-to-back)
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only in IDLE
//  stop     in   1      synchronous abort
//  pattern  in   WIDTH  bits to send; bit [len-1] goes first
//  len      in   LEN_W  number of bits per repetition, legal range 1..WIDTH
//  repeats  in   REP_W  repetitions; 0 = continuous until stop
//  x        out  1      serial data bit
//  x_valid  out  1      x carries a pattern bit this cycle
//  busy     out  1      transfer in progress (SHIFT or GAP)
//  done     out  1      one-cycle pulse after the final bit
//  err      out  1      one-cycle pulse when start is rejected for illegal len
// BEHAVIOUR
//  Outputs and reset:
//  - All outputs are registered.
//  - reset low: state=IDLE, x=0, x_valid=0, busy=0, done=0, err=0, all
//    counters 0. Takes effect immediately, with no clock edge, including in the
//    middle of a transfer.
//  States:
//  - IDLE -> SHIFT on start=1, stop=0 and 1<=len<=WIDTH.
//    - At that edge pattern, len and repeats are latched.
//    - At the same edge: x = pattern[len-1], x_valid=1, busy=1.
//    - Latency: the first bit is visible in the cycle right after start is
//      sampled.
//  - IDLE, start=1 with len=0 or len>WIDTH: err=1 for one cycle; stays IDLE.
//  - SHIFT: one bit per edge in order pattern[len-1] ... pattern[0].
//    - x_valid=1 for exactly len cycles per repetition.
//  - After the last bit of a repetition:
//    - More repetitions remain (or repeats=0) and GAP>0: go to GAP.
//    - More repetitions remain and GAP=0: the next repetition's first bit
//      follows at the next edge, with no bubble.
//    - Final repetition: go to IDLE. At that edge done=1, busy=0, x_valid=0,
//      x=0.
//  - GAP: x=0, x_valid=0, busy=1 for exactly GAP cycles, then SHIFT.
//  - done and err each last exactly one cycle.
//  Boundary conditions:
//  - Latched values are used for the whole transfer. Changes on pattern, len
//    or repeats while busy have no effect.
//  - start while busy is ignored.
//  - stop=1 in SHIFT or GAP: next edge goes to IDLE with x=0, x_valid=0,
//    busy=0 and no done pulse.
//  - stop and start together in IDLE: stop wins; start is ignored and err is
//    not raised.
//  - Counters: the bit index is LEN_W bits and the repeat counter is REP_W bits.
//    The repeat counter decrements per repetition and does not decrement when
//    repeats=0. No wrap-around is reachable.
//  - Total x_valid cycles = len*repeats. Total busy cycles =
//    len*repeats + GAP*(repeats-1).
// TESTING
//  T1: start, pattern=8'hA5, len=8, repeats=1 -> x=1,0,1,0,0,1,0,1 on 8
//      consecutive valid cycles; done pulses on the 9th; busy low from then.
//  T2: pattern=3'b111, len=3, repeats=2, GAP=2 -> x_valid pattern 1,1,1,0,0,1,1,1
//      with x=1 on every valid cycle; one done pulse; busy high for 8 cycles.
//  T3: len=0, then len=9 (WIDTH=8) -> err pulses once each; busy, x_valid and
//      done stay 0.
//  T4: repeats=0, pattern=2'b10, len=2 -> x toggles 1,0,(gap 0,0),1,0...
//      indefinitely. stop at cycle 20 -> x_valid=0 and busy=0 next edge, with
//      no done pulse.
//  T5: drop reset mid-SHIFT between clock edges -> x, x_valid and busy go to 0
//      immediately. Release reset, then start -> a normal transfer.
//  T6: during a transfer change pattern, len and repeats and pulse start ->
//      output is unchanged. In IDLE, start and stop together -> no transfer and
//      no err.

Source files
------------

// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - request/serial-output bundle for the serial test-sequence generator
//
// Signals:
//   start, stop        request and synchronous abort (master -> slave)
//   pattern, len       bits to send and number of bits per repetition
//   repeats            repetition count, 0 = continuous until stop
//   x, x_valid         serial data bit and its qualifier (slave -> master)
//   busy, done, err    transfer status, end pulse, rejected-start pulse
interface seq_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] repeats;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, pattern, len, repeats,
        input  x, x_valid, busy, done, err
    );

    modport slave (
        input  start, stop, pattern, len, repeats,
        output x, x_valid, busy, done, err
    );
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial test-sequence generator, MSB-first with repeat and idle gap
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    seq_gen_if slave: start/stop/pattern/len/repeats in,
//          x/x_valid/busy/done/err out (all outputs registered)
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP   = 2
) (
    input  logic     clk,
    input  logic     reset,
    seq_gen_if.slave bus
);

    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_q, pat_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] idx_q, idx_n;     // index of the bit currently on x
    logic [REP_W-1:0] rep_q, rep_n;     // repetitions left, including the current one
    logic             cont_q, cont_n;   // repeats was 0: run until stop
    logic [GAP_W-1:0] gap_q, gap_n;     // gap cycles left after the current one
    logic             x_n, x_valid_n, busy_n, done_n, err_n;
    logic             len_ok, last_rep;

    // Variable shift instead of a direct part-select keeps the index width
    // independent of WIDTH.
    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_ok   = (bus.len != '0) && (bus.len <= MAX_LEN);
    assign last_rep = !cont_q && (rep_q == REP_W'(1));

    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        len_n     = len_q;
        idx_n     = idx_q;
        rep_n     = rep_q;
        cont_n    = cont_q;
        gap_n     = gap_q;
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            S_IDLE: begin
                // stop has priority: a simultaneous start is neither run nor flagged
                if (bus.start && !bus.stop) begin
                    if (len_ok) begin
                        pat_n     = bus.pattern;
                        len_n     = bus.len;
                        rep_n     = bus.repeats;
                        cont_n    = (bus.repeats == '0);
                        idx_n     = bus.len - 1'b1;
                        x_n       = bit_at(bus.pattern, bus.len - 1'b1);
                        x_valid_n = 1'b1;
                        busy_n    = 1'b1;
                        state_n   = S_SHIFT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                end else if (idx_q != '0) begin
                    idx_n     = idx_q - 1'b1;
                    x_n       = bit_at(pat_q, idx_q - 1'b1);
                    x_valid_n = 1'b1;
                    busy_n    = 1'b1;
                end else if (last_rep) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    if (!cont_q) begin
                        rep_n = rep_q - 1'b1;
                    end
                    busy_n = 1'b1;
                    if (GAP == 0) begin
                        idx_n     = len_q - 1'b1;
                        x_n       = bit_at(pat_q, len_q - 1'b1);
                        x_valid_n = 1'b1;
                    end else begin
                        state_n = S_GAP;
                        gap_n   = GAP_LOAD;
                    end
                end
            end

            S_GAP: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                end else begin
                    busy_n = 1'b1;
                    if (gap_q == '0) begin
                        state_n   = S_SHIFT;
                        idx_n     = len_q - 1'b1;
                        x_n       = bit_at(pat_q, len_q - 1'b1);
                        x_valid_n = 1'b1;
                    end else begin
                        gap_n = gap_q - 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            cont_q      <= 1'b0;
            gap_q       <= '0;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state       <= state_n;
            pat_q       <= pat_n;
            len_q       <= len_n;
            idx_q       <= idx_n;
            rep_q       <= rep_n;
            cont_q      <= cont_n;
            gap_q       <= gap_n;
            bus.x       <= x_n;
            bus.x_valid <= x_valid_n;
            bus.busy    <= busy_n;
            bus.done    <= done_n;
            bus.err     <= err_n;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - self-checking bench for seq_gen
module tb_seq_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int GAP   = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Expected per-cycle outputs, packed as {x, x_valid, busy, done, err}
    logic [4:0] exp_q[$];

    seq_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) sif ();

    seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] obs();
        return {sif.x, sif.x_valid, sif.busy, sif.done, sif.err};
    endfunction

    // Reference: every repetition is len valid bits MSB-first, GAP idle-but-busy
    // cycles separate repetitions, then a done cycle and a quiet cycle.
    function automatic void build_model(input logic [7:0] pat, input int l, input int reps);
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int b = l - 1; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0, 1'b0});
            if (r < reps - 1)
                for (int g = 0; g < GAP; g++)
                    exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00000);
    endfunction

    // Runs one transfer. reps=0 means continuous; stop_at>=0 raises stop so that
    // cycle stop_at onward must be quiet. scr scrambles inputs while busy.
    task automatic run_xfer(input string name, input logic [7:0] pat, input int l,
                            input int reps, input bit scr, input int stop_at,
                            output int busy_cnt, output int done_cnt);
        int         n;
        logic [4:0] e;
        logic [4:0] o;
        build_model(pat, l, (reps == 0) ? 64 : reps);
        n        = (stop_at >= 0) ? stop_at + 2 : exp_q.size();
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        sif.pattern = pat;
        sif.len     = LEN_W'(l);
        sif.repeats = REP_W'(reps);
        sif.start   = 1'b1;
        sif.stop    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sif.start   = 1'b0;
            sif.stop    = 1'b0;
            sif.pattern = pat;
            sif.len     = LEN_W'(l);
            sif.repeats = REP_W'(reps);
            e = (stop_at >= 0 && i >= stop_at) ? 5'b00000 : exp_q[i];
            o = obs();
            busy_cnt += int'(o[2]);
            done_cnt += int'(o[1]);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s cycle %0d: got {x,xv,busy,done,err}=%b expected %b", name, i, o, e);
            end
            if (scr && e[2]) begin
                sif.pattern = 8'($urandom);
                sif.len     = LEN_W'($urandom_range(0, 15));
                sif.repeats = REP_W'($urandom);
                sif.start   = 1'($urandom);
            end
            if (stop_at >= 0 && i == stop_at - 1)
                sif.stop = 1'b1;
        end
    endtask

    task automatic test_reset();
        sif.start = 1'b0; sif.stop = 1'b0; sif.pattern = '0; sif.len = '0; sif.repeats = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (obs() !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: got %b expected 00000", obs());
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs() !== 5'b00000) begin
            fails++;
            $display("FAIL after_reset_idle: got %b expected 00000", obs());
        end
    endtask

    task automatic test_single();
        int bc, dc;
        run_xfer("single_a5", 8'hA5, 8, 1, 1'b0, -1, bc, dc);
        tests++;
        if (bc != 8 || dc != 1) begin
            fails++;
            $display("FAIL single_counts: got busy=%0d done=%0d expected busy=8 done=1", bc, dc);
        end
    endtask

    task automatic test_repeat_gap();
        int bc, dc;
        run_xfer("repeat_gap", 8'h07, 3, 2, 1'b0, -1, bc, dc);
        tests++;
        if (bc != 8 || dc != 1) begin
            fails++;
            $display("FAIL repeat_gap_counts: got busy=%0d done=%0d expected busy=8 done=1", bc, dc);
        end
    endtask

    task automatic test_illegal_len();
        int bad_len[3] = '{0, 9, 15};
        foreach (bad_len[k]) begin
            @(negedge clk);
            sif.pattern = 8'hFF;
            sif.len     = LEN_W'(bad_len[k]);
            sif.repeats = 4'd1;
            sif.start   = 1'b1;
            @(negedge clk);
            sif.start = 1'b0;
            tests++;
            if (obs() !== 5'b00001) begin
                fails++;
                $display("FAIL illegal_len_%0d: got %b expected 00001", bad_len[k], obs());
            end
            @(negedge clk);
            tests++;
            if (obs() !== 5'b00000) begin
                fails++;
                $display("FAIL illegal_len_%0d_after: got %b expected 00000", bad_len[k], obs());
            end
        end
    endtask

    task automatic test_continuous_stop();
        int bc, dc;
        run_xfer("continuous_stop", 8'h02, 2, 0, 1'b0, 20, bc, dc);
        tests++;
        if (dc != 0) begin
            fails++;
            $display("FAIL continuous_no_done: got done=%0d expected 0", dc);
        end
        run_xfer("stop_in_gap", 8'h05, 3, 3, 1'b0, 4, bc, dc);
    endtask

    task automatic test_async_reset();
        int bc, dc;
        @(negedge clk);
        sif.pattern = 8'hFF; sif.len = 4'd8; sif.repeats = 4'd1; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({sif.x, sif.x_valid, sif.busy} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset: got {x,xv,busy}=%b expected 000", {sif.x, sif.x_valid, sif.busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer("after_async_reset", 8'h3C, 6, 2, 1'b0, -1, bc, dc);
    endtask

    task automatic test_ignore_changes();
        int bc, dc;
        run_xfer("ignore_changes", 8'hB2, 7, 3, 1'b1, -1, bc, dc);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sif.pattern = 8'hAA;
            sif.len     = (k == 0) ? 4'd4 : 4'd0;
            sif.repeats = 4'd1;
            sif.start   = 1'b1;
            sif.stop    = 1'b1;
            @(negedge clk);
            sif.start = 1'b0;
            sif.stop  = 1'b0;
            tests++;
            if (obs() !== 5'b00000) begin
                fails++;
                $display("FAIL start_stop_idle_%0d: got %b expected 00000", k, obs());
            end
            @(negedge clk);
            tests++;
            if (obs() !== 5'b00000) begin
                fails++;
                $display("FAIL start_stop_idle_%0d_after: got %b expected 00000", k, obs());
            end
        end
    endtask

    task automatic test_random();
        int bc, dc, l, r;
        logic [7:0] p;
        for (int k = 0; k < 8; k++) begin
            p = 8'($urandom);
            l = $urandom_range(1, WIDTH);
            r = $urandom_range(1, 4);
            run_xfer("random", p, l, r, 1'($urandom), -1, bc, dc);
            tests++;
            if (bc != l * r + GAP * (r - 1) || dc != 1) begin
                fails++;
                $display("FAIL random_counts: got busy=%0d done=%0d expected busy=%0d done=1",
                         bc, dc, l * r + GAP * (r - 1));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_repeat_gap();
        test_illegal_len();
        test_continuous_stop();
        test_async_reset();
        test_ignore_changes();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
